// File: rtl/uart_tx_sched_if.sv
// Requester and uart_tx handshake bundle for uart_tx_sched.
// master: the scheduler side; slave: requesters plus uart_tx.
interface uart_tx_sched_if;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_end;

    modport master (
        input  req, req_data, tx_busy, tx_end,
        output ack, tx_start, tx_data
    );

    modport slave (
        output req, req_data, tx_busy, tx_end,
        input  ack, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between 4 byte requesters: round-robin arbiter into a
// circular FIFO, a sequencer driving the start/busy/end handshake, and a
// watchdog that drops a byte whose tx_end never arrives.
module uart_tx_sched #(
    parameter int unsigned      FIFO_AW  = 3,
    parameter int unsigned      TO_W     = 16,
    parameter logic [TO_W-1:0]  TO_LIMIT = {TO_W{1'b1}}
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_sched_if.master     bus,
    output logic [FIFO_AW:0]    fifo_cnt,
    output logic                irq_empty,
    output logic                err,
    input  logic                err_clr
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e             state_q, state_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         scan_idx;
    logic [1:0]         grant_idx;
    logic               grant_vld;
    logic [3:0]         ack;
    logic               full;
    logic               push;
    logic               pop;
    logic [7:0]         wdata;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   cnt_q, cnt_d;

    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               irq_q, irq_d;
    logic               err_q, err_d;
    logic               err_set;
    logic [TO_W-1:0]    wd_q, wd_d;
    logic               wd_expire;

    assign full  = (cnt_q == (FIFO_AW + 1)'(DEPTH));
    assign push  = |(bus.req & ack);
    assign wdata = bus.req_data[{grant_idx, 3'b000} +: 8];
    assign pop   = (state_q == StIdle) && (cnt_q != '0) && !bus.tx_busy;

    // The watchdog fires on the edge where the counter would reach TO_LIMIT,
    // so a stuck frame occupies exactly TO_LIMIT cycles in SEND.
    assign wd_expire = (({1'b0, wd_q} + (TO_W + 1)'(1)) == {1'b0, TO_LIMIT});

    // Round-robin grant: first requester after the last one served.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = last_q;
        scan_idx  = '0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last_q + 2'(k);
            if (!grant_vld && bus.req[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
        ack = '0;
        // Full blocks the grant even if a pop frees a slot on the same edge.
        if (grant_vld && !full && reset) begin
            ack[grant_idx] = 1'b1;
        end
    end

    // Pointer and occupancy next-state.
    always_comb begin
        last_d = push ? grant_idx : last_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + (FIFO_AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (FIFO_AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Sequencer next-state and registered handshake outputs.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        irq_d      = 1'b0;
        wd_d       = wd_q;
        err_set    = 1'b0;
        case (state_q)
            StIdle: begin
                // tx_end arriving here is stale and ignored.
                if (pop) begin
                    tx_data_d  = mem[rptr_q];
                    tx_start_d = 1'b1;
                    wd_d       = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (bus.tx_end) begin
                    state_d = StIdle;
                    irq_d   = (cnt_q == '0) && !push;
                end else if (wd_expire) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    // State registers; reset discards queued bytes and any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            last_q     <= 2'd3;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            irq_q      <= 1'b0;
            err_q      <= 1'b0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            irq_q      <= irq_d;
            err_q      <= err_d;
            wd_q       <= wd_d;
            if (push) begin
                wptr_q <= wptr_q + FIFO_AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + FIFO_AW'(1);
            end
        end
    end

    // FIFO storage needs no reset; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= wdata;
        end
    end

    assign bus.ack      = ack;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign fifo_cnt     = cnt_q;
    assign irq_empty    = irq_q;
    assign err          = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a vector table for arbitration and fill,
// then hand-written sequences for drain order, latency, watchdog and reset.
module tb_uart_tx_sched;

    logic       clk;
    logic       reset;
    logic       err_clr;
    logic [3:0] fifo_cnt;
    logic       irq_empty;
    logic       err;

    int checks = 0;
    int errors = 0;

    uart_tx_sched_if bif ();

    uart_tx_sched #(
        .FIFO_AW  (3),
        .TO_W     (16),
        .TO_LIMIT (16'd16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bif),
        .fifo_cnt  (fifo_cnt),
        .irq_empty (irq_empty),
        .err       (err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  exp_ack;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] exp_bytes [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1);
    end

    initial begin
        logic [31:0] data_a;
        logic [31:0] data_b;
        data_a = 32'hA3A2_A1A0;
        data_b = 32'hB3B2_B1B0;
        vecs[0] = '{4'hF, data_a, 1'b1, 4'b0001, 4'd0};
        vecs[1] = '{4'hF, data_a, 1'b1, 4'b0010, 4'd1};
        vecs[2] = '{4'hF, data_a, 1'b1, 4'b0100, 4'd2};
        vecs[3] = '{4'hF, data_a, 1'b1, 4'b1000, 4'd3};
        vecs[4] = '{4'hF, data_b, 1'b1, 4'b0001, 4'd4};
        vecs[5] = '{4'hF, data_b, 1'b1, 4'b0010, 4'd5};
        vecs[6] = '{4'hF, data_b, 1'b1, 4'b0100, 4'd6};
        vecs[7] = '{4'hF, data_b, 1'b1, 4'b1000, 4'd7};
        vecs[8] = '{4'hF, data_b, 1'b1, 4'b0000, 4'd8};
        exp_bytes = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hC0};

        // Reset held with every requester asserting.
        reset            = 1'b0;
        err_clr          = 1'b0;
        bif.req          = 4'hF;
        bif.req_data     = data_a;
        bif.tx_busy      = 1'b1;
        bif.tx_end       = 1'b0;
        @(negedge clk);
        #1;
        check("rst_ack", 32'(bif.ack), 32'h0);
        check("rst_tx_start", 32'(bif.tx_start), 32'h0);
        check("rst_tx_data", 32'(bif.tx_data), 32'h0);
        check("rst_cnt", 32'(fifo_cnt), 32'h0);
        check("rst_irq", 32'(irq_empty), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        reset = 1'b1;

        // Round-robin fill with uart_tx stalled.
        for (int i = 0; i < 9; i++) begin
            bif.req      = vecs[i].req;
            bif.req_data = vecs[i].data;
            bif.tx_busy  = vecs[i].busy;
            #1;
            check($sformatf("fill_ack[%0d]", i), 32'(bif.ack), 32'(vecs[i].exp_ack));
            check($sformatf("fill_cnt[%0d]", i), 32'(fifo_cnt), 32'(vecs[i].exp_cnt));
            @(negedge clk);
        end

        // Full: pop (with a stale tx_end) and request in the same cycle.
        bif.req      = 4'hF;
        bif.req_data = 32'hC3C2_C1C0;
        bif.tx_busy  = 1'b0;
        bif.tx_end   = 1'b1;
        #1;
        check("full_ack", 32'(bif.ack), 32'h0);
        check("full_cnt", 32'(fifo_cnt), 32'd8);
        @(negedge clk);
        bif.tx_end  = 1'b0;
        bif.tx_busy = 1'b1;
        #1;
        check("pop_cnt", 32'(fifo_cnt), 32'd7);
        check("pop_ack", 32'(bif.ack), 32'b0001);
        check("pop_start", 32'(bif.tx_start), 32'h1);
        check("pop_data", 32'(bif.tx_data), 32'hA0);
        @(negedge clk);
        bif.req = 4'h0;
        #1;
        check("refill_cnt", 32'(fifo_cnt), 32'd8);
        check("start_pulse", 32'(bif.tx_start), 32'h0);

        // Drain in FIFO order; next start one edge after tx_end.
        for (int i = 0; i < 9; i++) begin
            bif.tx_end = 1'b1;
            #1;
            check($sformatf("drain_data[%0d]", i), 32'(bif.tx_data), 32'(exp_bytes[i]));
            @(negedge clk);
            bif.tx_end  = 1'b0;
            bif.tx_busy = 1'b0;
            #1;
            check($sformatf("drain_irq[%0d]", i), 32'(irq_empty), (i == 8) ? 32'h1 : 32'h0);
            check($sformatf("drain_gap[%0d]", i), 32'(bif.tx_start), 32'h0);
            if (i < 8) begin
                @(negedge clk);
                bif.tx_busy = 1'b1;
                #1;
                check($sformatf("drain_start[%0d]", i), 32'(bif.tx_start), 32'h1);
                check($sformatf("drain_cnt[%0d]", i), 32'(fifo_cnt), 32'(7 - i));
                @(negedge clk);
            end
        end
        @(negedge clk);
        check("irq_one_cycle", 32'(irq_empty), 32'h0);

        // Single byte into an idle path.
        bif.req      = 4'b0100;
        bif.req_data = 32'h005A_0000;
        #1;
        check("single_ack", 32'(bif.ack), 32'b0100);
        @(negedge clk);
        bif.req = 4'h0;
        #1;
        check("single_cnt", 32'(fifo_cnt), 32'd1);
        check("single_nostart", 32'(bif.tx_start), 32'h0);
        @(negedge clk);
        check("single_start", 32'(bif.tx_start), 32'h1);
        check("single_data", 32'(bif.tx_data), 32'h5A);
        check("single_cnt0", 32'(fifo_cnt), 32'd0);
        @(negedge clk);
        check("single_pulse", 32'(bif.tx_start), 32'h0);
        bif.tx_end = 1'b1;
        @(negedge clk);
        bif.tx_end = 1'b0;
        check("single_irq", 32'(irq_empty), 32'h1);
        @(negedge clk);
        check("single_irq_off", 32'(irq_empty), 32'h0);

        // Watchdog: two bytes, tx_end withheld.
        bif.req      = 4'b0011;
        bif.req_data = 32'h0000_2211;
        #1;
        check("wd_ack0", 32'(bif.ack), 32'b0001);
        @(negedge clk);
        check("wd_ack1", 32'(bif.ack), 32'b0010);
        @(negedge clk);
        bif.req = 4'h0;
        check("wd_start", 32'(bif.tx_start), 32'h1);
        check("wd_data", 32'(bif.tx_data), 32'h11);
        check("wd_cnt", 32'(fifo_cnt), 32'd1);
        repeat (15) @(negedge clk);
        check("wd_before", 32'(err), 32'h0);
        check("wd_hold_data", 32'(bif.tx_data), 32'h11);
        @(negedge clk);
        check("wd_err", 32'(err), 32'h1);
        check("wd_no_irq", 32'(irq_empty), 32'h0);
        check("wd_idle", 32'(bif.tx_start), 32'h0);
        @(negedge clk);
        check("wd_next_start", 32'(bif.tx_start), 32'h1);
        check("wd_next_data", 32'(bif.tx_data), 32'h22);
        check("wd_err_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        repeat (15) @(negedge clk);
        check("wd_clr", 32'(err), 32'h0);
        @(negedge clk);
        check("wd_set_wins", 32'(err), 32'h1);
        check("wd_no_irq2", 32'(irq_empty), 32'h0);
        err_clr = 1'b0;
        @(negedge clk);
        check("wd_sticky2", 32'(err), 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("wd_clr2", 32'(err), 32'h0);

        // Reset mid-SEND with three bytes queued.
        bif.tx_busy  = 1'b0;
        bif.req      = 4'b0001;
        bif.req_data = 32'h0000_0077;
        #1;
        check("rst6_ack", 32'(bif.ack), 32'b0001);
        repeat (4) @(negedge clk);
        bif.req = 4'hF;
        #1;
        check("rst6_cnt", 32'(fifo_cnt), 32'd3);
        check("rst6_data", 32'(bif.tx_data), 32'h77);
        reset = 1'b0;
        #1;
        check("rst6_cnt0", 32'(fifo_cnt), 32'd0);
        check("rst6_start", 32'(bif.tx_start), 32'h0);
        check("rst6_ack0", 32'(bif.ack), 32'h0);
        @(negedge clk);
        reset       = 1'b1;
        bif.req     = 4'h0;
        bif.tx_end  = 1'b1;
        bif.tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst6_irq[%0d]", i), 32'(irq_empty), 32'h0);
            check($sformatf("rst6_quiet[%0d]", i), 32'(bif.tx_start), 32'h0);
        end
        bif.tx_end = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
